// File: rtl/riscv_fetch.sv
// ============================================================================
// Module   : riscv_fetch
// Function : single-outstanding instruction fetch stage with redirect and fault slots
// Revision : 1.0
// ============================================================================
`default_nettype none

module riscv_fetch #(
   parameter logic [31:0] BOOT_ADDR = 32'h8000_0000
) (
   input  logic        InClk,
   input  logic        InRstN,
   input  logic        InBranch,
   input  logic [31:0] InBranchPc,
   output logic        OutIcacheRd,
   output logic [31:0] OutIcachePc,
   input  logic        InIcacheAccept,
   input  logic        InIcacheValid,
   input  logic        InIcacheError,
   input  logic [31:0] InIcacheInst,
   output logic        OutFetchValid,
   output logic [31:0] OutFetchInstr,
   output logic [31:0] OutFetchPc,
   output logic        OutFetchFault,
   input  logic        InFetchAccept
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } fetchStateT;

   fetchStateT  r_state;
   fetchStateT  w_stateNext;
   logic [31:0] r_pc;
   logic [31:0] w_pcNext;
   logic        r_drop;
   logic        w_dropNext;
   logic [31:0] r_slotInstr;
   logic [31:0] r_slotPc;
   logic        r_slotFault;
   logic        w_load;
   logic [31:0] w_loadInstr;
   logic        w_loadFault;
   logic        w_pcAligned;
   logic        w_reqFire;

   assign w_pcAligned   = (r_pc[1:0] == 2'b00);
   // A misaligned PC never reaches memory; REQ turns it into a fault slot instead.
   assign OutIcacheRd   = InRstN && (r_state == ST_REQ) && w_pcAligned;
   assign OutIcachePc   = r_pc;
   assign w_reqFire     = OutIcacheRd && InIcacheAccept;
   assign OutFetchValid = (r_state == ST_HOLD);
   assign OutFetchInstr = r_slotInstr;
   assign OutFetchPc    = r_slotPc;
   assign OutFetchFault = r_slotFault;

   always_comb begin
      w_stateNext = r_state;
      w_pcNext    = r_pc;
      w_dropNext  = r_drop && !InIcacheValid;
      w_load      = 1'b0;
      w_loadInstr = 32'h0;
      w_loadFault = 1'b0;
      case (r_state)
         ST_REQ: begin
            if (InBranch) begin
               w_pcNext = InBranchPc;
               // The old address was already taken by memory: its data must be thrown away.
               if (w_reqFire) begin
                  w_stateNext = ST_WAIT;
                  w_dropNext  = 1'b1;
               end
            end else if (!w_pcAligned) begin
               w_stateNext = ST_HOLD;
               w_load      = 1'b1;
               w_loadFault = 1'b1;
            end else if (w_reqFire) begin
               w_stateNext = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (InIcacheValid) begin
               if (r_drop || InBranch) begin
                  w_stateNext = ST_REQ;
                  if (InBranch) begin
                     w_pcNext = InBranchPc;
                  end
               end else begin
                  w_stateNext = ST_HOLD;
                  w_load      = 1'b1;
                  w_loadFault = InIcacheError;
                  w_loadInstr = InIcacheError ? 32'h0 : InIcacheInst;
               end
            end else if (InBranch) begin
               w_pcNext   = InBranchPc;
               w_dropNext = 1'b1;
            end
         end
         ST_HOLD: begin
            if (InBranch) begin
               w_stateNext = ST_REQ;
               w_pcNext    = InBranchPc;
            end else if (InFetchAccept) begin
               if (r_slotFault) begin
                  w_stateNext = ST_FAULT;
               end else begin
                  w_stateNext = ST_REQ;
                  w_pcNext    = r_pc + 32'd4;
               end
            end
         end
         ST_FAULT: begin
            if (InBranch) begin
               w_stateNext = ST_REQ;
               w_pcNext    = InBranchPc;
            end
         end
         default: begin
            w_stateNext = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge InClk) begin
      if (!InRstN) begin
         r_state     <= ST_REQ;
         r_pc        <= BOOT_ADDR;
         // Remember a request abandoned by reset so its late response is not taken as fresh data.
         r_drop      <= (r_drop || (r_state == ST_WAIT)) && !InIcacheValid;
         r_slotInstr <= 32'h0;
         r_slotPc    <= BOOT_ADDR;
         r_slotFault <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_pc    <= w_pcNext;
         r_drop  <= w_dropNext;
         if (w_load) begin
            r_slotInstr <= w_loadInstr;
            r_slotPc    <= r_pc;
            r_slotFault <= w_loadFault;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch.sv
// ============================================================================
// Module   : tb_riscv_fetch
// Function : directed and randomized checks of riscv_fetch against a program-order model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_fetch;

   localparam logic [31:0] BOOT = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rstN;
   logic        branch;
   logic [31:0] branchPc;
   logic        icRd;
   logic [31:0] icPc;
   logic        icAccept;
   logic        icValid;
   logic        icError;
   logic [31:0] icInst;
   logic        fValid;
   logic [31:0] fInstr;
   logic [31:0] fPc;
   logic        fFault;
   logic        fetchAccept;

   int vectors     = 0;
   int miscompares = 0;

   riscv_fetch #(.BOOT_ADDR(BOOT)) dut (
      .InClk          (clk),
      .InRstN         (rstN),
      .InBranch       (branch),
      .InBranchPc     (branchPc),
      .OutIcacheRd    (icRd),
      .OutIcachePc    (icPc),
      .InIcacheAccept (icAccept),
      .InIcacheValid  (icValid),
      .InIcacheError  (icError),
      .InIcacheInst   (icInst),
      .OutFetchValid  (fValid),
      .OutFetchInstr  (fInstr),
      .OutFetchPc     (fPc),
      .OutFetchFault  (fFault),
      .InFetchAccept  (fetchAccept)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory takes the request now and answers one cycle later.
   task automatic fetchAt(input logic [31:0] inst, input logic err);
      icAccept = 1'b1;
      tick();
      icAccept = 1'b0;
      icValid  = 1'b1;
      icInst   = inst;
      icError  = err;
      tick();
      icValid  = 1'b0;
      icError  = 1'b0;
   endtask

   function automatic logic [31:0] memData(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic isErr(input logic [31:0] a);
      logic [7:0] w;
      w = a[9:2];
      return (w % 8'd23) == 8'd5;
   endfunction

   // program-order model state
   logic [31:0] expPc;
   logic        halted;
   logic        memBusy;
   logic [31:0] memAddr;
   int          memCnt;
   logic        prevHold;
   logic        prevBranch;
   logic [31:0] prevPc;
   logic [31:0] prevInstr;
   logic        prevFault;
   int          accepted;
   logic [31:0] tmp;
   logic        expFault;
   logic [31:0] expInstr;
   logic        pend;
   logic        got;

   initial begin
      rstN = 1'b0; branch = 1'b0; branchPc = 32'h0; icAccept = 1'b0;
      icValid = 1'b0; icError = 1'b0; icInst = 32'h0; fetchAccept = 1'b0;
      repeat (3) tick();
      chk1("rstRd", icRd, 1'b0);
      chk1("rstValid", fValid, 1'b0);
      chk1("rstFault", fFault, 1'b0);
      chk("rstInstr", fInstr, 32'h0);
      chk("rstFetchPc", fPc, BOOT);
      chk("rstIcPc", icPc, BOOT);

      // first fetch after reset
      rstN = 1'b1;
      #1;
      chk1("rdAfterRst", icRd, 1'b1);
      chk("icPcBoot", icPc, BOOT);
      icAccept = 1'b1;
      tick();
      icAccept = 1'b0;
      chk1("rdInWait", icRd, 1'b0);
      chk1("validInWait", fValid, 1'b0);
      icValid = 1'b1; icInst = 32'h0000_0013;
      tick();
      icValid = 1'b0;
      chk1("firstValid", fValid, 1'b1);
      chk("firstPc", fPc, BOOT);
      chk("firstInstr", fInstr, 32'h0000_0013);
      chk1("firstFault", fFault, 1'b0);

      // downstream stall holds the slot
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("stallValid", fValid, 1'b1);
         chk("stallInstr", fInstr, 32'h0000_0013);
         chk("stallPc", fPc, BOOT);
         chk1("stallRd", icRd, 1'b0);
      end
      fetchAccept = 1'b1;
      tick();
      fetchAccept = 1'b0;
      chk1("postAcceptValid", fValid, 1'b0);
      chk1("postAcceptRd", icRd, 1'b1);
      chk("postAcceptPc", icPc, BOOT + 32'd4);

      // redirect while waiting: stale word is dropped
      icAccept = 1'b1;
      tick();
      icAccept = 1'b0;
      branch = 1'b1; branchPc = 32'h8000_0100;
      tick();
      branch = 1'b0;
      chk1("dropRdWait", icRd, 1'b0);
      icValid = 1'b1; icInst = 32'hDEAD_BEEF;
      tick();
      icValid = 1'b0;
      chk1("dropNoValid", fValid, 1'b0);
      chk1("dropRd", icRd, 1'b1);
      chk("dropIcPc", icPc, 32'h8000_0100);
      fetchAt(32'h0000_0093, 1'b0);
      chk1("brValid", fValid, 1'b1);
      chk("brPc", fPc, 32'h8000_0100);
      chk("brInstr", fInstr, 32'h0000_0093);
      fetchAccept = 1'b1;
      tick();
      fetchAccept = 1'b0;

      // bus error becomes a fault slot and halts fetch
      fetchAt(32'h1234_5678, 1'b1);
      chk1("errValid", fValid, 1'b1);
      chk1("errFault", fFault, 1'b1);
      chk("errInstr", fInstr, 32'h0);
      chk("errPc", fPc, 32'h8000_0104);
      fetchAccept = 1'b1;
      tick();
      fetchAccept = 1'b0;
      chk1("haltValid", fValid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("haltRd", icRd, 1'b0);
      end
      branch = 1'b1; branchPc = 32'h8000_0200;
      tick();
      branch = 1'b0;
      chk1("resumeRd", icRd, 1'b1);
      chk("resumePc", icPc, 32'h8000_0200);

      // misaligned target: fault slot without a memory request
      branch = 1'b1; branchPc = 32'h8000_0102;
      tick();
      branch = 1'b0;
      chk1("misRd", icRd, 1'b0);
      chk1("misValid0", fValid, 1'b0);
      tick();
      chk1("misValid", fValid, 1'b1);
      chk1("misFault", fFault, 1'b1);
      chk("misPc", fPc, 32'h8000_0102);
      chk("misInstr", fInstr, 32'h0);
      chk1("misRd2", icRd, 1'b0);
      fetchAccept = 1'b1;
      tick();
      fetchAccept = 1'b0;
      chk1("misHaltRd", icRd, 1'b0);

      // branch beats accept; PC wrap
      branch = 1'b1; branchPc = 32'h8000_0300;
      tick();
      branch = 1'b0;
      fetchAt(32'h0000_0113, 1'b0);
      branch = 1'b1; branchPc = 32'h0000_0040; fetchAccept = 1'b1;
      tick();
      branch = 1'b0; fetchAccept = 1'b0;
      chk1("winValid", fValid, 1'b0);
      chk1("winRd", icRd, 1'b1);
      chk("winPc", icPc, 32'h0000_0040);
      branch = 1'b1; branchPc = 32'hFFFF_FFFC;
      tick();
      branch = 1'b0;
      fetchAt(32'h0000_0213, 1'b0);
      chk("wrapSlotPc", fPc, 32'hFFFF_FFFC);
      fetchAccept = 1'b1;
      tick();
      fetchAccept = 1'b0;
      chk1("wrapRd", icRd, 1'b1);
      chk("wrapPc", icPc, 32'h0);

      // reset while a request is outstanding; its late answer must not surface
      icAccept = 1'b1;
      tick();
      icAccept = 1'b0;
      rstN = 1'b0;
      tick();
      tick();
      rstN = 1'b1;
      #1;
      chk1("midRstRd", icRd, 1'b1);
      chk("midRstPc", icPc, BOOT);
      icAccept = 1'b1;
      tick();
      icAccept = 1'b0;
      icValid = 1'b1; icInst = 32'h0BAD_0BAD;
      tick();
      icValid = 1'b0;
      pend = 1'b0; got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (fValid) begin
            got = 1'b1;
         end else begin
            icValid  = pend;
            icInst   = 32'h0000_0513;
            pend     = icRd;
            icAccept = icRd;
            tick();
         end
      end
      icAccept = 1'b0; icValid = 1'b0;
      chk1("midRstGot", got, 1'b1);
      chk("midRstInstr", fInstr, 32'h0000_0513);
      chk("midRstSlotPc", fPc, BOOT);
      fetchAccept = 1'b1;
      tick();
      fetchAccept = 1'b0;

      // randomized traffic against the program-order model
      rstN = 1'b0;
      tick();
      tick();
      rstN = 1'b1;
      #1;
      expPc = BOOT; halted = 1'b0; memBusy = 1'b0; memAddr = 32'h0; memCnt = 0;
      prevHold = 1'b0; prevBranch = 1'b0; prevPc = 32'h0; prevInstr = 32'h0;
      prevFault = 1'b0; accepted = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tmp = $urandom;
         if (memBusy && memCnt == 1) begin
            icValid = 1'b1;
            icInst  = memData(memAddr);
            icError = isErr(memAddr);
            memBusy = 1'b0;
         end else begin
            icValid = 1'b0;
            icInst  = $urandom;
            icError = tmp[0];
            if (memBusy) memCnt--;
         end
         icAccept = 1'b0;
         if (icRd) begin
            chk("reqPc", icPc, expPc);
            chk1("oneOutstanding", memBusy, 1'b0);
            if ($urandom % 10 < 7) begin
               icAccept = 1'b1;
               memBusy  = 1'b1;
               memAddr  = icPc;
               memCnt   = $urandom_range(1, 3);
            end
         end
         if (halted) chk1("rdWhileHalted", icRd, 1'b0);
         fetchAccept = ($urandom % 10 < 6);
         branch      = ($urandom % 100 < (halted ? 30 : 6));
         tmp = $urandom;
         case ($urandom % 8)
            0:       branchPc = {16'h8000, tmp[15:2], (tmp[16] ? 2'b10 : 2'b11)};
            1:       branchPc = {28'hFFFF_FFF, tmp[3:2], 2'b00};
            default: branchPc = {16'h8000, tmp[15:2], 2'b00};
         endcase
         if (prevHold) begin
            chk1("holdValid", fValid, 1'b1);
            chk("holdPc", fPc, prevPc);
            chk("holdInstr", fInstr, prevInstr);
            chk1("holdFault", fFault, prevFault);
         end
         if (prevBranch) chk1("validAfterBranch", fValid, 1'b0);
         if (fValid && fetchAccept && !branch) begin
            expFault = (expPc[1:0] != 2'b00) || isErr(expPc);
            expInstr = expFault ? 32'h0 : memData(expPc);
            chk("slotPc", fPc, expPc);
            chk1("slotFault", fFault, expFault);
            chk("slotInstr", fInstr, expInstr);
            accepted++;
            if (expFault) halted = 1'b1;
            else          expPc  = expPc + 32'd4;
         end
         if (branch) begin
            expPc  = branchPc;
            halted = 1'b0;
         end
         prevHold   = fValid && !fetchAccept && !branch;
         prevPc     = fPc;
         prevInstr  = fInstr;
         prevFault  = fFault;
         prevBranch = branch;
         tick();
      end
      branch = 1'b0; fetchAccept = 1'b0; icAccept = 1'b0; icValid = 1'b0;
      chk1("slotsAccepted", accepted >= 100, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
